// File: rtl/dep_scoreboard.sv
// dep_scoreboard: RAW hazard unit between decode and issue. Shadows DEPTH
// in-flight register writes and holds decode (valid/ready) while a source
// register has a pending write. Optional bypass: DEP_SCOREBOARD_BYPASS_EN.
// Ports: clk, rst (async high); issue_valid/issue_ready handshake; rs1, rs2,
// check_rs1, check_rs2, rd, reg_we from decode; flush; fwd_rs1, fwd_rs2;
// busy_mask; stall_count (saturating); deadlock_err (sticky watchdog).
module dep_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int DEPTH       = 3,
  parameter int STALL_CNT_W = 16,
  localparam int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [ADDR_W-1:0]      rs1,
  input  logic [ADDR_W-1:0]      rs2,
  input  logic                   check_rs1,
  input  logic                   check_rs2,
  input  logic [ADDR_W-1:0]      rd,
  input  logic                   reg_we,
  input  logic                   flush,
  output logic                   fwd_rs1,
  output logic                   fwd_rs2,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   deadlock_err
);

  localparam int WD_W = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(DEPTH);

  // Stages that can stall decode; the writeback stage drops out when bypassed.
`ifdef DEP_SCOREBOARD_BYPASS_EN
  localparam logic [DEPTH-1:0] ELIG =
    DEPTH'((64'd1 << (DEPTH - 1)) - 64'd1);
`else
  localparam logic [DEPTH-1:0] ELIG = '1;
`endif

  logic [DEPTH-1:0]  vld;
  logic [ADDR_W-1:0] rdq [DEPTH];
  logic [DEPTH-1:0]  m1;
  logic [DEPTH-1:0]  m2;
  logic              hazard;
  logic              fire;
  logic              load;
  logic              stall;
  logic [WD_W-1:0]   wd;

  assign fire  = issue_valid & issue_ready;
  assign load  = fire & reg_we & (rd != '0) & ~flush;
  assign stall = issue_valid & ~issue_ready & ~flush;

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      m1[k] = vld[k] && (rdq[k] == rs1) && check_rs1 && (rs1 != '0);
      m2[k] = vld[k] && (rdq[k] == rs2) && check_rs2 && (rs2 != '0);
    end
  end

  assign hazard      = |((m1 | m2) & ELIG);
  assign issue_ready = ~hazard;

`ifdef DEP_SCOREBOARD_BYPASS_EN
  // Bypass only when no younger write to the same register is in flight.
  assign fwd_rs1 = m1[DEPTH-1] & ~|(m1 & ELIG);
  assign fwd_rs2 = m2[DEPTH-1] & ~|(m2 & ELIG);
`else
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
`endif

  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < DEPTH; k++)
      if (vld[k]) busy_mask[rdq[k]] = 1'b1;
  end

  // Shadow pipeline shifts every cycle; bubbles fill non-issue cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) rdq[k] <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        vld[k] <= vld[k-1] & ~flush;
        rdq[k] <= rdq[k-1];
      end
      vld[0] <= load;
      rdq[0] <= rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && !(&stall_count)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  // A legal stall never outlasts DEPTH cycles; one more means deadlock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd           <= '0;
      deadlock_err <= 1'b0;
    end else if (!stall) begin
      wd <= '0;
    end else begin
      if (wd == WD_MAX) deadlock_err <= 1'b1;
      else              wd <= wd + 1'b1;
    end
  end

endmodule

// File: doc/dep_scoreboard.md
# dep_scoreboard

Parametrised read-after-write hazard unit for the in-order pipeline, sitting between decode and the issue point. Tracks every in-flight register write in an internal shadow pipeline of DEPTH stages, so downstream stages no longer have to export their rd/reg_we. Holds the decode instruction with a valid/ready handshake while any source register has a pending write. Also provides optional writeback bypass, flush, stall statistics and a deadlock watchdog.

## Interface
- NUM_REGS, 32: architectural register count; ADDR_W = $clog2(NUM_REGS).
- DEPTH, 3: in-flight stages after issue tracked for hazards (≥1); stage DEPTH-1 is writeback.
- STALL_CNT_W, 16: width of stall statistics counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode holds a valid instruction.
- issue_ready  out  1  no unresolved hazard; issue fires on issue_valid & issue_ready.
- rs1, rs2  in  ADDR_W  source register indices of the decode instruction.
- check_rs1, check_rs2  in  1  source is actually read (from microcode).
- rd  in  ADDR_W  destination index of the decode instruction.
- reg_we  in  1  decode instruction writes rd.
- flush  in  1  kill all in-flight entries and the decode instruction.
- fwd_rs1, fwd_rs2  out  1  operand must be taken from writeback bypass (0 unless bypass is compiled in).
- busy_mask  out  NUM_REGS  bit r set when any valid entry targets r.
- stall_count  out  STALL_CNT_W  saturating count of stall cycles.
- deadlock_err  out  1  sticky watchdog error.

## Operation
- Shadow pipeline: DEPTH entries {valid, rd}; shifts every cycle unconditionally (downstream never stalls; bubbles enter on non-issue cycles).
- Entry 0 load: valid = issue fire & reg_we & (rd != 0) & ~flush; else bubble.
- flush: on next edge all entries invalid; a simultaneous issue is not recorded. flush has no effect on issue_ready.
- Match at stage k: entry k valid & entry.rd == rs & check_rs & rs != 0. x0 never hazards.
- Hazard = any match on rs1 or rs2 at any hazard-eligible stage. issue_ready = ~hazard, combinational, independent of issue_valid.
- Decode instruction whose own rd equals its rs is not a hazard.
- busy_mask: OR-decode of all valid entries, combinational from registered state.
- Stall cycle = issue_valid & ~issue_ready & ~flush. stall_count increments per stall cycle, saturates at all-ones, cleared only by rst.
- Watchdog: counter of consecutive stall cycles; exceeding DEPTH sets deadlock_err (cannot occur in correct operation); cleared only by rst.

## Timing
- Reset: all entries invalid, busy_mask 0, stall_count 0, watchdog 0, deadlock_err 0, fwd_* 0, issue_ready 1.
- Issue of a writer to rd=r in cycle n: entry occupies stages 0..DEPTH-1 in cycles n+1..n+DEPTH; gone from n+DEPTH+1.
- Dependent reader presented in n+1, no bypass: issue_ready low n+1..n+DEPTH, high n+DEPTH+1.
- Multiple writers to same r: youngest governs release; stall ends when no valid entry matches.
- issue_ready/fwd_* have zero latency from rs/check inputs; no other combinational path from inputs to registered state.
- Flush in cycle n: from n+1 no entries, issue_ready high for any rs.

## Configuration
- DEP_SCOREBOARD_BYPASS_EN defined: stage DEPTH-1 is not hazard-eligible; fwd_rs1/fwd_rs2 assert when that stage matches and no younger stage matches. Dependent reader stalls DEPTH-1 cycles, issues in n+DEPTH with fwd set.
- Undefined: all stages hazard-eligible; fwd_rs1/fwd_rs2 tied 0.

## Test plan
- Reset mid-stall: writer r5 issued, reader rs1=5 stalled, assert rst -> issue_ready 1, busy_mask 0, stall_count 0 immediately.
- DEPTH=3, no bypass: issue rd=5 we=1 in cycle 0, reader rs1=5 check_rs1=1 from cycle 1 -> ready low cycles 1-3, fire cycle 4, stall_count=3.
- Same with BYPASS_EN -> ready low cycles 1-2, fire cycle 3 with fwd_rs1=1, fwd_rs2=0, stall_count=2.
- x0 and unchecked: writer rd=0, then reader rs1=0; writer rd=7, reader rs2=7 check_rs2=0 -> no stall, busy_mask 0 then bit 7 only.
- Flush: writer rd=9 cycle 0, flush cycle 1 with reader rs1=9 -> ready high cycle 2, busy_mask 0; issue during flush leaves no entry.
- Saturation/watchdog: STALL_CNT_W=2, three separate 3-cycle stalls -> stall_count sticks at 3; force stall_valid via backdoor-held entry beyond DEPTH -> deadlock_err 1 until rst.
